board_renderer: RTL and testbench

Pixel-colour source for the Snake display path. Holds the game board as a 40×30 grid of 2-bit cell codes in on-chip RAM, written by game logic. Each clock it converts the pixel coordinate produced by the VGA controller into 1-bit R/G/B for that controller's colour inputs. It also provides a board-clear sweep and a once-per-frame pulse so that game logic updates the board during vertical blank.

---
 rtl/snake_pkg.sv | 35 +++
 rtl/board_renderer_if.sv | 12 +
 rtl/board_ram.sv | 23 ++
 rtl/board_renderer.sv | 150 +++++++++++++++
 tb/tb_board_renderer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the Snake display path: board geometry, cell codes and
// the helpers that map cells to RAM addresses and colours.
package snake_pkg;

  localparam int CELL_SHIFT = 4;
  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BODY  = 2'd1;
  localparam logic [1:0] HEAD  = 2'd2;
  localparam logic [1:0] FOOD  = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clear_state_t;

  // y*40 + x built from shifts so no multiplier is inferred
  function automatic logic [10:0] cell_addr(input logic [4:0] cy, input logic [5:0] cx);
    return {1'b0, cy, 5'd0} + {3'd0, cy, 3'd0} + {5'd0, cx};
  endfunction

  function automatic logic [2:0] cell_rgb(input logic [1:0] code);
    case (code)
      BODY:    return 3'b010;
      HEAD:    return 3'b110;
      FOOD:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Game-logic side of the board: cell writes, clear request and sweep status.
interface board_renderer_if;
  logic       iWr_En;
  logic [5:0] iWr_X;
  logic [4:0] iWr_Y;
  logic [1:0] iWr_Cell;
  logic       iClear;
  logic       oBusy;

  modport master (output iWr_En, iWr_X, iWr_Y, iWr_Cell, iClear, input oBusy);
  modport slave  (input iWr_En, iWr_X, iWr_Y, iWr_Cell, iClear, output oBusy);
endinterface

// File: rtl/board_ram.sv
// Simple dual-port 2-bit cell store, synchronous read with read-before-write,
// written so it maps onto a block RAM.
module board_ram #(
  parameter int DEPTH = 1200
) (
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [10:0] i_waddr,
  input  logic [1:0]  i_wdata,
  input  logic [10:0] i_raddr,
  output logic [1:0]  o_rdata
);

  logic [1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/board_renderer.sv
// Board store plus pixel colour pipeline for the Snake display.
// state    | meaning
// ST_IDLE  | accepting cell writes, waiting for a clear request
// ST_CLEAR | sweeping EMPTY over every cell, one per cycle; writes ignored
module board_renderer #(
  parameter int CELL_SHIFT = snake_pkg::CELL_SHIFT,
  parameter int GRID_W     = snake_pkg::GRID_W,
  parameter int GRID_H     = snake_pkg::GRID_H
) (
  input  logic       iCLK,
  input  logic       reset,
  input  logic [9:0] iCurrent_X,
  input  logic [9:0] iCurrent_Y,
  output logic       oRed,
  output logic       oGreen,
  output logic       oBlue,
  output logic       oFrame_Done,
  board_renderer_if.slave bus
);
  import snake_pkg::clear_state_t;
  import snake_pkg::ST_IDLE;
  import snake_pkg::ST_CLEAR;
  import snake_pkg::EMPTY;
  import snake_pkg::cell_addr;
  import snake_pkg::cell_rgb;

  localparam int          CELLS     = GRID_W * GRID_H;
  localparam logic [10:0] LAST_ADDR = 11'(CELLS - 1);
  localparam logic [9:0]  H_ACT     = 10'(snake_pkg::H_ACTIVE);
  localparam logic [9:0]  V_ACT     = 10'(snake_pkg::V_ACTIVE);
  localparam logic [9:0]  H_LAST    = 10'(snake_pkg::H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST    = 10'(snake_pkg::V_ACTIVE - 1);
  localparam logic [5:0]  GW        = 6'(GRID_W);
  localparam logic [4:0]  GH        = 5'(GRID_H);

  clear_state_t r_state, w_state_nxt;
  logic [10:0]  r_cnt, w_cnt_nxt;
  logic         w_we;
  logic [10:0]  w_waddr;
  logic [1:0]   w_wdata;
  logic         w_wr_ok;

  logic [5:0]   w_cx;
  logic [4:0]   w_cy;
  logic         w_in_range;
  logic         w_border;
  logic         w_last_px;
  logic [10:0]  w_raddr;
  logic [1:0]   w_rdata;

  logic         r_in_range;
  logic         r_border;
  logic         r_last_px;
  logic [2:0]   r_rgb;
  logic         r_frame_done;

  // ---------------- clear sweep / write arbitration ----------------
  assign w_wr_ok = (bus.iWr_X < GW) && (bus.iWr_Y < GH);

  always_ff @(posedge iCLK) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_waddr     = cell_addr(bus.iWr_Y, bus.iWr_X);
    w_wdata     = bus.iWr_Cell;
    case (r_state)
      ST_IDLE: begin
        if (bus.iClear) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end else if (bus.iWr_En && w_wr_ok) begin
          w_we = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = EMPTY;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 11'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.oBusy = (r_state == ST_CLEAR);

  // ---------------- pixel pipeline ----------------
  assign w_cx       = 6'(iCurrent_X >> CELL_SHIFT);
  assign w_cy       = 5'(iCurrent_Y >> CELL_SHIFT);
  assign w_in_range = (iCurrent_X < H_ACT) && (iCurrent_Y < V_ACT);
  assign w_border   = (iCurrent_X == 10'd0) || (iCurrent_X == H_LAST) ||
                      (iCurrent_Y == 10'd0) || (iCurrent_Y == V_LAST);
  assign w_last_px  = (iCurrent_X == H_LAST) && (iCurrent_Y == V_LAST);
  // Off-screen coordinates would alias past the last cell, so park the read
  assign w_raddr    = w_in_range ? cell_addr(w_cy, w_cx) : 11'd0;

  board_ram #(
    .DEPTH (CELLS)
  ) u_board_ram (
    .i_clk   (iCLK),
    .i_we    (w_we && reset),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge iCLK) begin
    if (!reset) begin
      r_in_range   <= 1'b0;
      r_border     <= 1'b0;
      r_last_px    <= 1'b0;
      r_rgb        <= 3'b000;
      r_frame_done <= 1'b0;
    end else begin
      r_in_range   <= w_in_range;
      r_border     <= w_border;
      r_last_px    <= w_in_range && w_last_px;
      r_frame_done <= r_last_px;
      if (!r_in_range) begin
        r_rgb <= 3'b000;
      end else if (r_border) begin
        r_rgb <= 3'b111;
      end else begin
        r_rgb <= cell_rgb(w_rdata);
      end
    end
  end

  assign oRed        = r_rgb[2];
  assign oGreen      = r_rgb[1];
  assign oBlue       = r_rgb[0];
  assign oFrame_Done = r_frame_done;

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: table-driven pixel vectors scored
// through a latency-tagged queue, plus hand sequences for the clear sweep.
module tb_board_renderer;

  logic       clk;
  logic       reset;
  logic [9:0] cur_x;
  logic [9:0] cur_y;
  logic       o_red, o_green, o_blue, o_fd;

  board_renderer_if bus();

  board_renderer dut (
    .iCLK        (clk),
    .reset       (reset),
    .iCurrent_X  (cur_x),
    .iCurrent_Y  (cur_y),
    .oRed        (o_red),
    .oGreen      (o_green),
    .oBlue       (o_blue),
    .oFrame_Done (o_fd),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] rgb;
    logic       fd;
    int         x;
    int         y;
  } sb_t;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] rgb;
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t tbl[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_fd = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_fd) n_fd++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (mon_e.due != cyc || {o_red, o_green, o_blue} != mon_e.rgb || o_fd != mon_e.fd) begin
        n_fail++;
        $display("FAIL pix(%0d,%0d) got rgb=%b fd=%b want rgb=%b fd=%b",
                 mon_e.x, mon_e.y, {o_red, o_green, o_blue}, o_fd, mon_e.rgb, mon_e.fd);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input int x, input int y, input logic [2:0] rgb);
    cur_x = 10'(x);
    cur_y = 10'(y);
    sb.push_back('{cyc + 2, rgb, logic'(x == 639 && y == 479), x, y});
    tick(1);
  endtask

  task automatic wr(input int x, input int y, input logic [1:0] c);
    bus.iWr_En   = 1'b1;
    bus.iWr_X    = 6'(x);
    bus.iWr_Y    = 5'(y);
    bus.iWr_Cell = c;
    tick(1);
    bus.iWr_En   = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.iClear = 1'b1;
    tick(1);
    bus.iClear = 1'b0;
  endtask

  // Board at scan time: everything EMPTY except FOOD in the last cell
  function automatic logic [2:0] scan_exp(input int x, input int y);
    if (x >= 640 || y >= 480) return 3'b000;
    if (x == 0 || x == 639 || y == 0 || y == 479) return 3'b111;
    if ((x >> 4) == 39 && (y >> 4) == 29) return 3'b100;
    return 3'b000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int fd_before;

    for (int x = 80; x <= 95; x++) tbl.push_back('{x, 48, 3'b110});
    tbl.push_back('{96, 48, 3'b000});
    tbl.push_back('{0, 200, 3'b111});
    tbl.push_back('{639, 10, 3'b111});
    tbl.push_back('{300, 479, 3'b111});
    tbl.push_back('{700, 100, 3'b000});
    tbl.push_back('{640, 0, 3'b000});
    tbl.push_back('{1023, 479, 3'b000});
    tbl.push_back('{100, 500, 3'b000});
    tbl.push_back('{85, 49, 3'b110});

    reset        = 1'b0;
    cur_x        = 10'd0;
    cur_y        = 10'd0;
    bus.iWr_En   = 1'b0;
    bus.iWr_X    = '0;
    bus.iWr_Y    = '0;
    bus.iWr_Cell = '0;
    bus.iClear   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_rgb", int'({o_red, o_green, o_blue}), 0);
    chk("reset_busy", int'(bus.oBusy), 0);
    chk("reset_fd", int'(o_fd), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1);

    // Post-reset clear: busy for exactly 1200 cycles
    pulse_clear();
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.oBusy) cnt++;
      else if (cnt > 0) break;
    end
    chk("clear_busy_len", cnt, 1200);
    tick(1);
    pix(100, 100, 3'b000);
    tick(3);

    // Single write then table vectors including border/range cases
    wr(5, 3, snake_pkg::HEAD);
    foreach (tbl[i]) pix(tbl[i].x, tbl[i].y, tbl[i].rgb);
    tick(3);

    // Full sweep with a re-clear and a write landing mid-sweep
    pulse_clear();
    cnt = 0;
    bus.iWr_X    = 6'd1;
    bus.iWr_Y    = 5'd1;
    bus.iWr_Cell = snake_pkg::HEAD;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.oBusy) cnt++;
      else if (cnt > 0) break;
      @(posedge clk);
      #1;
      bus.iClear = (cnt == 600);
      bus.iWr_En = (cnt == 1000);
    end
    bus.iClear = 1'b0;
    bus.iWr_En = 1'b0;
    chk("sweep_ignores_reclear", cnt, 1200);
    tick(1);
    pix(20, 20, 3'b000);
    pix(85, 50, 3'b000);
    tick(3);

    // Dropped out-of-range writes, then the last cell
    wr(40, 0, snake_pkg::FOOD);
    wr(0, 30, snake_pkg::FOOD);
    wr(41, 1, snake_pkg::FOOD);
    pix(8, 20, 3'b000);
    pix(24, 40, 3'b000);
    pix(630, 470, 3'b000);
    wr(39, 29, snake_pkg::FOOD);
    pix(630, 470, 3'b100);
    wr(1, 1, snake_pkg::BODY);
    pix(20, 20, 3'b010);
    tick(3);

    // Clear beats a simultaneous write; reset aborts the sweep at cycle 500
    bus.iClear   = 1'b1;
    bus.iWr_En   = 1'b1;
    bus.iWr_X    = 6'd39;
    bus.iWr_Y    = 5'd28;
    bus.iWr_Cell = snake_pkg::HEAD;
    tick(1);
    bus.iClear = 1'b0;
    bus.iWr_En = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.oBusy) cnt++;
      if (cnt >= 500) break;
    end
    chk("abort_reach_500", cnt, 500);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", int'(bus.oBusy), 0);
    chk("abort_rgb", int'({o_red, o_green, o_blue}), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1);
    pix(20, 20, 3'b000);
    pix(630, 470, 3'b100);
    pix(630, 455, 3'b000);
    tick(3);

    // Bottom of the frame with blanking, then the top row
    fd_before = n_fd;
    for (int y = 478; y <= 479; y++)
      for (int x = 0; x < 800; x++) pix(x, y, scan_exp(x, y));
    for (int x = 0; x < 10; x++) pix(x, 0, scan_exp(x, 0));
    tick(4);
    chk("frame_pulse_count", n_fd - fd_before, 1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
